// File: rtl/branch_resolver.sv
// Front-end client of the 2-bit branch predictor with an in-order in-flight queue.
// Optional statistics counters are built only when BR_STATS_EN is defined.
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_fetch,
    output logic             fetch_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             br_resolve,
    input  logic             br_actual,
    output logic             mispredict,
    output logic             request,
    input  logic             prediction,
    output logic             result,
    output logic             taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t state, state_nxt;

    logic [DEPTH-1:0] q;
    logic [AW-1:0]    head, tail;
    logic [AW:0]      count;
    logic             full, empty, pop, push, flush;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign pop   = br_resolve && !empty;
    assign flush = pop && (q[head] != br_actual);
    // A flush wipes the queue, so the in-flight prediction is wrong-path too.
    assign push  = (state == WAIT) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        request     = 1'b0;
        pred_valid  = 1'b0;
        pred_taken  = 1'b0;
        fetch_ready = 1'b0;
        unique case (state)
            IDLE: begin
                fetch_ready = !full;
                if (br_fetch && !full) state_nxt = REQ;
            end
            REQ: begin
                request   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                pred_valid = 1'b1;
                pred_taken = prediction;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q[tail] <= prediction;
                tail    <= tail + AW'(1);
            end
            if (pop) head <= head + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= 1'b0;
            taken      <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            result     <= pop;
            taken      <= pop && br_actual;
            mispredict <= flush;
        end
    end

`ifdef BR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (pop && (branch_count != '1))
                branch_count <= branch_count + CNT_W'(1);
            if (flush && (mispredict_count != '1))
                mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (DEPTH=4, CNT_W=2).
// Counter expectations follow BR_STATS_EN in the same way as the design.
module tb_branch_resolver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       br_fetch, br_resolve, br_actual, prediction;
    logic       fetch_ready, pred_valid, pred_taken;
    logic       mispredict, request, result, taken;
    logic [1:0] branch_count, mispredict_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_resolver #(.DEPTH(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_fetch(br_fetch), .fetch_ready(fetch_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .br_resolve(br_resolve), .br_actual(br_actual),
        .mispredict(mispredict), .request(request),
        .prediction(prediction), .result(result), .taken(taken),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        br_fetch = 1'b0; br_resolve = 1'b0;
        br_actual = 1'b0; prediction = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic do_fetch(input logic p);
        br_fetch = 1'b1; prediction = p;
        step();
        br_fetch = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        pulse_reset();
        n_cmp++; if (request !== 1'b0) begin n_bad++; $display("FAIL rst_request got %b want 0", request); end
        n_cmp++; if (pred_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pred_valid got %b want 0", pred_valid); end
        n_cmp++; if ({result, taken, mispredict} !== 3'b000) begin n_bad++; $display("FAIL rst_res got %b want 000", {result, taken, mispredict}); end
        n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL rst_fetch_ready got %b want 1", fetch_ready); end
        n_cmp++; if ({branch_count, mispredict_count} !== 4'h0) begin n_bad++; $display("FAIL rst_counts got %h want 0", {branch_count, mispredict_count}); end
    endtask

    task automatic test_fetch();
        br_fetch = 1'b1; prediction = 1'b1;
        step();
        br_fetch = 1'b0;
        n_cmp++; if ({request, pred_valid} !== 2'b10) begin n_bad++; $display("FAIL fetch_req got %b want 10", {request, pred_valid}); end
        step();
        n_cmp++; if ({request, pred_valid, pred_taken} !== 3'b011) begin n_bad++; $display("FAIL fetch_pred got %b want 011", {request, pred_valid, pred_taken}); end
        step();
        n_cmp++; if ({pred_valid, pred_taken, fetch_ready} !== 3'b001) begin n_bad++; $display("FAIL fetch_done got %b want 001", {pred_valid, pred_taken, fetch_ready}); end
        n_cmp++; if (dut.count !== 3'd1) begin n_bad++; $display("FAIL fetch_count got %0d want 1", dut.count); end
    endtask

    task automatic test_full();
        do_fetch(1'b1); do_fetch(1'b0); do_fetch(1'b1);
        n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", fetch_ready); end
        n_cmp++; if (dut.count !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d want 4", dut.count); end
        br_fetch = 1'b1;
        step();
        br_fetch = 1'b0;
        n_cmp++; if (request !== 1'b0) begin n_bad++; $display("FAIL full_noreq got %b want 0", request); end
        br_resolve = 1'b1; br_actual = 1'b1;
        step();
        br_resolve = 1'b0;
        n_cmp++; if ({result, taken, mispredict} !== 3'b110) begin n_bad++; $display("FAIL full_pop got %b want 110", {result, taken, mispredict}); end
        n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready2 got %b want 1", fetch_ready); end
        n_cmp++; if (dut.count !== 3'd3) begin n_bad++; $display("FAIL full_count2 got %0d want 3", dut.count); end
    endtask

    task automatic test_mispredict();
        br_resolve = 1'b1; br_actual = 1'b0;
        step();
        n_cmp++; if ({result, taken, mispredict} !== 3'b101) begin n_bad++; $display("FAIL mis_pulse got %b want 101", {result, taken, mispredict}); end
        n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL mis_count got %0d want 0", dut.count); end
        step();
        br_resolve = 1'b0;
        n_cmp++; if ({result, mispredict} !== 2'b00) begin n_bad++; $display("FAIL mis_empty got %b want 00", {result, mispredict}); end
    endtask

    task automatic test_back_to_back();
        do_fetch(1'b0); do_fetch(1'b1);
        br_resolve = 1'b1; br_actual = 1'b0;
        step();
        br_actual = 1'b1;
        n_cmp++; if ({result, taken, mispredict} !== 3'b100) begin n_bad++; $display("FAIL b2b_first got %b want 100", {result, taken, mispredict}); end
        step();
        br_resolve = 1'b0;
        n_cmp++; if ({result, taken, mispredict} !== 3'b110) begin n_bad++; $display("FAIL b2b_second got %b want 110", {result, taken, mispredict}); end
        step();
        n_cmp++; if (result !== 1'b0) begin n_bad++; $display("FAIL b2b_end got %b want 0", result); end
    endtask

    task automatic test_flush_push();
        do_fetch(1'b1);
        br_fetch = 1'b1; prediction = 1'b0;
        step();
        br_fetch = 1'b0;
        step();
        n_cmp++; if (pred_valid !== 1'b1) begin n_bad++; $display("FAIL flush_inwait got %b want 1", pred_valid); end
        br_resolve = 1'b1; br_actual = 1'b0;
        step();
        br_resolve = 1'b0;
        n_cmp++; if ({mispredict, pred_valid} !== 2'b10) begin n_bad++; $display("FAIL flush_pulse got %b want 10", {mispredict, pred_valid}); end
        n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", dut.count); end
        n_cmp++; if ({fetch_ready, request} !== 2'b10) begin n_bad++; $display("FAIL flush_idle got %b want 10", {fetch_ready, request}); end
    endtask

    task automatic test_stats();
        logic [1:0] e2, e5;
`ifdef BR_STATS_EN
        e2 = 2'd2; e5 = 2'd3;
`else
        e2 = 2'd0; e5 = 2'd0;
`endif
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            do_fetch(1'b1);
            br_resolve = 1'b1; br_actual = 1'b0;
            step();
            br_resolve = 1'b0;
            if (i == 1) begin
                n_cmp++; if ({branch_count, mispredict_count} !== {e2, e2}) begin n_bad++; $display("FAIL stats_mid got %h want %h", {branch_count, mispredict_count}, {e2, e2}); end
            end
        end
        n_cmp++; if (branch_count !== e5) begin n_bad++; $display("FAIL stats_branch got %0d want %0d", branch_count, e5); end
        n_cmp++; if (mispredict_count !== e5) begin n_bad++; $display("FAIL stats_mis got %0d want %0d", mispredict_count, e5); end
    endtask

    task automatic test_reset_mid();
        do_fetch(1'b0); do_fetch(1'b1);
        br_fetch = 1'b1;
        step();
        br_fetch = 1'b0;
        n_cmp++; if (request !== 1'b1) begin n_bad++; $display("FAIL rmid_req got %b want 1", request); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if ({request, pred_valid, result, mispredict} !== 4'b0000) begin n_bad++; $display("FAIL rmid_outs got %b want 0000", {request, pred_valid, result, mispredict}); end
        n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL rmid_count got %0d want 0", dut.count); end
        #2 rst_n = 1'b1;
        step();
        n_cmp++; if ({fetch_ready, request} !== 2'b10) begin n_bad++; $display("FAIL rmid_after got %b want 10", {fetch_ready, request}); end
        n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL rmid_count2 got %0d want 0", dut.count); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_full();
        test_mispredict();
        test_back_to_back();
        test_flush_push();
        test_stats();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
